// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit controller.
// Op codes match the main controller's MDU decode.
package mdu_ctrl_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    // Ops 0..3 occupy the unit for several cycles.
    function automatic logic is_mul_div(input logic [2:0] op);
        return !op[2];
    endfunction

    function automatic logic is_mult(input logic [2:0] op);
        return op[2:1] == 2'b00;
    endfunction

endpackage

// File: rtl/mdu_ctrl_calc.sv
// Combinational MDU datapath: 64-bit {hi,lo} result per op.
// Divide by zero returns the current {hi,lo}.
module mdu_ctrl_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res
);

    logic        div_signed;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    assign div_signed = (op == MDU_DIV);

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // One divider on magnitudes; 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    assign mag_a = a[31] ? (32'd0 - a) : a;
    assign mag_b = b[31] ? (32'd0 - b) : b;
    assign div_a = div_signed ? mag_a : a;
    assign div_b = div_signed ? mag_b : b;
    assign quo   = (div_b == 32'd0) ? 32'd0 : div_a / div_b;
    assign rem   = (div_b == 32'd0) ? 32'd0 : div_a % div_b;

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign quo_s = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
    assign rem_s = a[31] ? (32'd0 - rem) : rem;

    // Select the result for the current op.
    always_comb begin
        res = {hi, lo};
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV:   res = (b == 32'd0) ? {hi, lo} : {rem_s, quo_s};
            MDU_DIVU:  res = (b == 32'd0) ? {hi, lo} : {rem, quo};
            default:   res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: busy-counter FSM, pending result, HI/LO registers.
// stall_req holds D-stage MDU instructions while an op is in flight.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_in_d,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    mdu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] pending_q, pending_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] calc_res;
    logic        start_mul_div;

    mdu_ctrl_calc u_calc (
        .op  (mdu_op),
        .a   (src_a),
        .b   (src_b),
        .hi  (hi_q),
        .lo  (lo_q),
        .res (calc_res)
    );

    assign start_mul_div = start && is_mul_div(mdu_op) && (state_q == S_IDLE);
    assign busy          = (state_q == S_BUSY);
    assign stall_req     = md_in_d && (busy || start_mul_div);
    assign hi            = hi_q;
    assign lo            = lo_q;

    // Next-state, counter, pending and HI/LO update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_mul_div) begin
                    pending_d = calc_res;
                    cnt_d     = is_mult(mdu_op) ? CW'(MULT_CYC) : CW'(DIV_CYC);
                    state_d   = S_BUSY;
                end else if (start && mdu_op == MDU_MTHI) begin
                    hi_d = src_a;
                end else if (start && mdu_op == MDU_MTLO) begin
                    lo_d = src_a;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = pending_q[63:32];
                    lo_d    = pending_q[31:0];
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

`ifndef SYNTHESIS
    // A mul/div restart while busy means the hazard unit failed to stall.
    always @(posedge clk) begin
        if (reset && state_q == S_BUSY && start) begin
            assert (!is_mul_div(mdu_op))
            else $error("mdu_ctrl: mul/div start while busy");
        end
    end
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, hand sequences,
// and random ops against a plain-arithmetic reference model.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_in_d;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mdu_op    (mdu_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .md_in_d   (md_in_d),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: results from the arithmetic definitions of each op.
    function automatic logic [63:0] ref_calc(input logic [2:0] op,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] h, input logic [31:0] l);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     r;
        sa = $signed(a);
        sb = $signed(b);
        ua = 64'(a);
        ub = 64'(b);
        r  = {h, l};
        case (op)
            3'd0: r = sa * sb;
            3'd1: r = ua * ub;
            3'd2: if (b != 0) begin
                sq = sa / sb;
                sr = sa % sb;
                r  = {sr[31:0], sq[31:0]};
            end
            3'd3: if (b != 0) begin
                uq = ua / ub;
                ur = ua % ub;
                r  = {ur[31:0], uq[31:0]};
            end
            3'd4: r = {a, l};
            3'd5: r = {h, a};
            default: r = {h, l};
        endcase
        return r;
    endfunction

    function automatic int ref_cyc(input logic [2:0] op);
        if (op <= 3'd1) return 5;
        if (op <= 3'd3) return 10;
        return 0;
    endfunction

    // Issue one op for a single cycle, then count busy cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cyc);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        src_a  = a;
        src_b  = b;
        @(negedge clk);
        start  = 1'b0;
        src_a  = $urandom;
        src_b  = $urandom;
        cyc    = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    vec_t vt[12];
    int   cyc;
    int   n_stall;
    logic [63:0] m;
    logic [31:0] m_hi, m_lo;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        vt[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vt[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vt[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[3]  = '{3'd2, 32'd100,      32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vt[5]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
        vt[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vt[7]  = '{3'd0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vt[8]  = '{3'd4, 32'h00001234, 32'd9,        32'h00001234, 32'h00000000, 0};
        vt[9]  = '{3'd5, 32'h00005678, 32'd9,        32'h00001234, 32'h00005678, 0};
        vt[10] = '{3'd6, 32'hDEADBEEF, 32'd1,        32'h00001234, 32'h00005678, 0};
        vt[11] = '{3'd3, 32'd5,        32'd0,        32'h00001234, 32'h00005678, 10};

        reset   = 1'b0;
        start   = 1'b0;
        mdu_op  = 3'd0;
        src_a   = 32'd0;
        src_b   = 32'd0;
        md_in_d = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_stall", 64'(stall_req), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;

        // Directed vectors, applied in order (div-by-zero rows keep prior HI/LO).
        for (int i = 0; i < 12; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, cyc);
            chk($sformatf("vec%0d_cyc", i), 64'(cyc), 64'(vt[i].exp_cyc));
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vt[i].exp_hi));
            chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vt[i].exp_lo));
        end

        // mthi then mtlo back to back: busy must never rise.
        @(negedge clk);
        start = 1'b1; mdu_op = 3'd4; src_a = 32'h0000AAAA;
        @(negedge clk);
        chk("mthi_busy", 64'(busy), 64'd0);
        mdu_op = 3'd5; src_a = 32'h0000BBBB;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mthi_mtlo_hilo", {hi, lo}, {32'h0000AAAA, 32'h0000BBBB});

        // stall_req across a div, with starts pulsed while busy.
        md_in_d = 1'b1;
        @(negedge clk);
        chk("stall_idle", 64'(stall_req), 64'd0);
        start = 1'b1; mdu_op = 3'd2; src_a = 32'd100; src_b = 32'd7;
        #1;
        chk("stall_start_cycle", 64'(stall_req), 64'd1);
        n_stall = 1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (stall_req && cyc < 40) begin
            cyc++;
            n_stall++;
            if (cyc == 3) begin
                start = 1'b1; mdu_op = 3'd4; src_a = 32'hDEAD0000;
            end else if (cyc == 5) begin
                start = 1'b1; mdu_op = 3'd6; src_a = 32'hBEEF0000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("stall_total", 64'(n_stall), 64'd11);
        chk("busy_start_ignored", {hi, lo}, {32'd2, 32'd14});
        md_in_d = 1'b0;
        #1;
        chk("stall_released", 64'(stall_req), 64'd0);

        // Reset in the middle of a mult.
        @(negedge clk);
        start = 1'b1; mdu_op = 3'd0; src_a = 32'd1000; src_b = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("reset_mid_busy", 64'(busy), 64'd0);
        chk("reset_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(3'd0, 32'hFFFFFFFF, 32'd7, cyc);
        chk("post_reset_cyc", 64'(cyc), 64'd5);
        chk("post_reset_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF9);

        // Random ops against the reference model.
        m_hi = hi;
        m_lo = lo;
        for (int k = 0; k < 60; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end
            if ($urandom_range(0, 4) == 0) rb = 32'($urandom_range(1, 20));
            m = ref_calc(rop, ra, rb, m_hi, m_lo);
            m_hi = m[63:32];
            m_lo = m[31:0];
            run_op(rop, ra, rb, cyc);
            chk($sformatf("rnd%0d_op%0d_cyc", k, rop), 64'(cyc), 64'(ref_cyc(rop)));
            chk($sformatf("rnd%0d_op%0d_hilo", k, rop), {hi, lo}, {m_hi, m_lo});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
